// File: rtl/vga_text_typer_if.sv
// Port bundle between the pixel pipeline/controller and the typewriter letter feeder.
// The master drives pacing, message selection and slot index; the slave returns the letter code and status.
interface vga_text_typer_if;
  logic       frame_tick;
  logic       start;
  logic [1:0] msg_sel;
  logic [2:0] slot;
  logic [4:0] letter;
  logic       busy;
  logic       done;

  modport master (
    output frame_tick,
    output start,
    output msg_sel,
    output slot,
    input  letter,
    input  busy,
    input  done
  );

  modport slave (
    input  frame_tick,
    input  start,
    input  msg_sel,
    input  slot,
    output letter,
    output busy,
    output done
  );
endinterface

// File: rtl/vga_text_typer.sv
// Typewriter-style letter feeder: reveals one of four fixed messages one letter per
// FRAMES_PER_CHAR frame ticks, holds it for HOLD_FRAMES ticks, then pulses done.
module vga_text_typer #(
  parameter int unsigned FRAMES_PER_CHAR = 8,
  parameter int unsigned HOLD_FRAMES     = 60
) (
  input  logic           clk,
  input  logic           rst,
  vga_text_typer_if.slave bus
);

  localparam logic [4:0] BLANK     = 5'd31;
  localparam logic [7:0] FPC_LAST  = 8'(FRAMES_PER_CHAR - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TYPE = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] msg_q;
  logic [3:0] reveal_cnt;
  logic [7:0] frame_cnt;
  logic [3:0] len_q;
  logic [4:0] letter;
  logic       done;

  // Message ROM: START, CLEAR, SCORE, BLOCKS; unused slots are blank.
  function automatic logic [4:0] rom_letter(input logic [1:0] msg, input logic [2:0] idx);
    logic [4:0] code;
    code = BLANK;
    case (msg)
      2'd0: begin
        case (idx)
          3'd0:    code = 5'd18;
          3'd1:    code = 5'd19;
          3'd2:    code = 5'd0;
          3'd3:    code = 5'd17;
          3'd4:    code = 5'd19;
          default: code = BLANK;
        endcase
      end
      2'd1: begin
        case (idx)
          3'd0:    code = 5'd2;
          3'd1:    code = 5'd11;
          3'd2:    code = 5'd4;
          3'd3:    code = 5'd0;
          3'd4:    code = 5'd17;
          default: code = BLANK;
        endcase
      end
      2'd2: begin
        case (idx)
          3'd0:    code = 5'd18;
          3'd1:    code = 5'd2;
          3'd2:    code = 5'd14;
          3'd3:    code = 5'd17;
          3'd4:    code = 5'd4;
          default: code = BLANK;
        endcase
      end
      2'd3: begin
        case (idx)
          3'd0:    code = 5'd1;
          3'd1:    code = 5'd11;
          3'd2:    code = 5'd14;
          3'd3:    code = 5'd2;
          3'd4:    code = 5'd10;
          3'd5:    code = 5'd18;
          default: code = BLANK;
        endcase
      end
      default: code = BLANK;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] rom_len(input logic [1:0] msg);
    logic [3:0] len;
    case (msg)
      2'd3:    len = 4'd6;
      default: len = 4'd5;
    endcase
    return len;
  endfunction

  // Sequencer: start always wins over a coincident frame tick, which is then dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      msg_q      <= 2'd0;
      reveal_cnt <= 4'd0;
      frame_cnt  <= 8'd0;
      len_q      <= 4'd0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.start) begin
        msg_q      <= bus.msg_sel;
        len_q      <= rom_len(bus.msg_sel);
        reveal_cnt <= 4'd0;
        frame_cnt  <= 8'd0;
        state      <= TYPE;
      end else if (bus.frame_tick) begin
        case (state)
          TYPE: begin
            if (frame_cnt == FPC_LAST) begin
              frame_cnt  <= 8'd0;
              reveal_cnt <= reveal_cnt + 4'd1;
              if ((reveal_cnt + 4'd1) == len_q) begin
                state <= HOLD;
              end else begin
                state <= TYPE;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
          HOLD: begin
            if (frame_cnt == HOLD_LAST) begin
              frame_cnt <= 8'd0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
          default: state <= state;
        endcase
      end else begin
        state <= state;
      end
    end
  end

  // Letter lookup uses the reveal count as it stood before this edge's update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      letter <= BLANK;
    end else if ((state != IDLE) && ({1'b0, bus.slot} < reveal_cnt)) begin
      letter <= rom_letter(msg_q, bus.slot);
    end else begin
      letter <= BLANK;
    end
  end

  assign bus.letter = letter;
  assign bus.done   = done;
  assign bus.busy   = (state == TYPE) || (state == HOLD);

endmodule

// File: tb/tb_vga_text_typer.sv
// Scoreboard bench for vga_text_typer with FRAMES_PER_CHAR=2, HOLD_FRAMES=3.
// Stimulus queues expected outputs per cycle; a monitor pops and compares after each edge.
module tb_vga_text_typer;

  logic clk;
  logic rst;
  vga_text_typer_if bus ();

  vga_text_typer #(
    .FRAMES_PER_CHAR(2),
    .HOLD_FRAMES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] letter;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   cyc_mon = 0;
  int   tests   = 0;
  int   fails   = 0;

  // Hand-written letter codes: START, CLEAR, SCORE, BLOCKS.
  logic [4:0] tbl [4][8] = '{
    '{5'd18, 5'd19, 5'd0,  5'd17, 5'd19, 5'd31, 5'd31, 5'd31},
    '{5'd2,  5'd11, 5'd4,  5'd0,  5'd17, 5'd31, 5'd31, 5'd31},
    '{5'd18, 5'd2,  5'd14, 5'd17, 5'd4,  5'd31, 5'd31, 5'd31},
    '{5'd1,  5'd11, 5'd14, 5'd2,  5'd10, 5'd18, 5'd31, 5'd31}
  };

  // Monitor: after each rising edge, compare every entry due on this cycle.
  always @(posedge clk) begin
    exp_t e;
    cyc_mon = cyc_mon + 1;
    #2;
    while (sb.size() > 0 && sb[0].cyc <= cyc_mon) begin
      e = sb.pop_front();
      tests = tests + 1;
      if (e.cyc != cyc_mon || bus.letter !== e.letter || bus.busy !== e.busy || bus.done !== e.done) begin
        fails = fails + 1;
        $display("FAIL sb cyc=%0d/%0d letter got %0d exp %0d busy got %0b exp %0b done got %0b exp %0b",
                 cyc_mon, e.cyc, bus.letter, e.letter, bus.busy, e.busy, bus.done, e.done);
      end
    end
  end

  task automatic check_now(input string name, input logic [4:0] exp_letter, input logic exp_busy, input logic exp_done);
    tests = tests + 1;
    if (bus.letter !== exp_letter || bus.busy !== exp_busy || bus.done !== exp_done) begin
      fails = fails + 1;
      $display("FAIL %s letter got %0d exp %0d busy got %0b exp %0b done got %0b exp %0b",
               name, bus.letter, exp_letter, bus.busy, exp_busy, bus.done, exp_done);
    end
  endtask

  // One clock of stimulus, optionally queueing the expected result of the next edge.
  task automatic cyc(input logic ft, input logic st, input logic [1:0] ms, input logic [2:0] sl,
                     input logic chk, input logic [4:0] el, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    bus.frame_tick = ft;
    bus.start      = st;
    bus.msg_sel    = ms;
    bus.slot       = sl;
    if (chk) begin
      e.cyc    = cyc_mon + 1;
      e.letter = el;
      e.busy   = eb;
      e.done   = ed;
      sb.push_back(e);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic start_msg(input logic [1:0] m);
    cyc(1'b0, 1'b1, m, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Walk slots 0..7, one per cycle, expecting the first nrev letters of msg m.
  task automatic sweep(input int m, input int nrev, input logic eb);
    for (int s = 0; s < 8; s++) begin
      cyc(1'b0, 1'b0, 2'd0, 3'(s), 1'b1, (s < nrev) ? tbl[m][s] : 5'd31, eb, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.msg_sel    = 2'd0;
    bus.slot       = 3'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_now("reset_state", 5'd31, 1'b0, 1'b0);

    // Idle ticks are ignored; everything stays blank.
    ticks(3);
    sweep(0, 0, 1'b0);

    // Partial reveal, then asynchronous reset mid-cycle.
    start_msg(2'd0);
    ticks(2);
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 5'd18, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_now("async_reset", 5'd31, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    sweep(0, 0, 1'b0);

    // Typing START.
    start_msg(2'd0);
    ticks(2);
    sweep(0, 1, 1'b1);
    ticks(8);
    sweep(0, 5, 1'b1);

    // Hold: done on the third tick, busy falls with it.
    cyc(1'b1, 1'b0, 2'd0, 3'd0, 1'b1, 5'd18, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 3'd0, 1'b1, 5'd18, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 3'd0, 1'b1, 5'd18, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 3'd1, 1'b1, 5'd19, 1'b0, 1'b0);
    ticks(5);
    sweep(0, 5, 1'b0);
    for (int s = 7; s >= 0; s--) cyc(1'b0, 1'b0, 2'd0, 3'(s), 1'b1, tbl[0][s], 1'b0, 1'b0);

    // Long message BLOCKS.
    start_msg(2'd3);
    ticks(12);
    sweep(3, 6, 1'b1);

    // Restart collision: start with a coincident tick mid-CLEAR.
    start_msg(2'd1);
    ticks(4);
    sweep(1, 2, 1'b1);
    cyc(1'b1, 1'b1, 2'd2, 3'd0, 1'b1, 5'd2, 1'b1, 1'b0);
    sweep(2, 0, 1'b1);
    ticks(1);
    sweep(2, 0, 1'b1);
    ticks(1);
    sweep(2, 1, 1'b1);

    // Drain scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL sb_drain pending got %0d exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
